// File: rtl/instruction_encoder.sv
// Two-stage valid/ready encoder that packs decoded RV32 instruction fields back into 32-bit words.
// Stage 1 holds the validated fields and an error flag; stage 2 holds the packed word.
module instruction_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [1:0]  in_group,
    input  logic        in_specifier,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [20:0] in_imm20,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        s1_valid_q;
    logic [6:0]  s1_opcode_q;
    logic [1:0]  s1_group_q;
    logic        s1_spec_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [4:0]  s1_rd_q;
    logic [20:0] s1_imm_q;
    logic        s1_err_q;

    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    logic [15:0] enc_count_q;
    logic [7:0]  err_count_q;

    logic        s1_adv;
    logic        s2_adv;
    logic        in_err;
    logic [31:0] packed_word;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Immediate legality: every bit above the format's range must replicate its sign bit.
    always_comb begin
        in_err = 1'b0;
        case (in_group)
            2'b01: in_err = in_specifier && (in_imm20[20:12] != {9{in_imm20[11]}});
            2'b10: begin
                if (in_specifier) begin
                    in_err = (in_imm20[20:13] != {8{in_imm20[12]}}) || in_imm20[0];
                end else begin
                    in_err = in_imm20[20:12] != {9{in_imm20[11]}};
                end
            end
            2'b11:   in_err = in_specifier ? in_imm20[0] : in_imm20[20];
            default: in_err = 1'b1;
        endcase
    end

    always_comb begin
        packed_word = Nop;
        if (!s1_err_q) begin
            case ({s1_group_q, s1_spec_q})
                3'b010: packed_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                                       s1_opcode_q};
                3'b011: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                                       s1_opcode_q};
                3'b100: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                       s1_imm_q[4:0], s1_opcode_q};
                3'b101: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                                       s1_funct3_q, s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                3'b110: packed_word = {s1_imm_q[19:0], s1_rd_q, s1_opcode_q};
                3'b111: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                                       s1_imm_q[19:12], s1_rd_q, s1_opcode_q};
                default: packed_word = Nop;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= '0;
            s1_group_q  <= '0;
            s1_spec_q   <= 1'b0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_rd_q     <= '0;
            s1_imm_q    <= '0;
            s1_err_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_opcode_q <= in_opcode;
                s1_group_q  <= in_group;
                s1_spec_q   <= in_specifier;
                s1_funct3_q <= in_funct3;
                s1_funct7_q <= in_funct7;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_rd_q     <= in_rd;
                s1_imm_q    <= in_imm20;
                s1_err_q    <= in_err;
            end
        end
    end

    // The word only changes when a new one is loaded, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= packed_word;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            enc_count_q <= enc_count_q + 16'd1;
            if (s2_err_q && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: table of hand-encoded vectors plus
// backpressure, error-counter saturation and mid-stream reset sequences.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [1:0]  in_group = '0;
    logic        in_specifier = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic [20:0] in_imm20 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    instruction_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_group     (in_group),
        .in_specifier (in_specifier),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_imm20     (in_imm20),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_err      (out_err),
        .enc_count    (enc_count),
        .err_count    (err_count)
    );

    typedef struct {
        logic [6:0]  op;
        logic [1:0]  grp;
        logic        spec;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [20:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    localparam int NumVecs = 17;
    vec_t vecs[NumVecs];
    int n_checks = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic [1:0] grp, input logic spec,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [20:0] imm,
                                input logic [31:0] instr, input logic err);
        vec_t v;
        v.op = op; v.grp = grp; v.spec = spec; v.f3 = f3; v.f7 = f7;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.instr = instr; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_opcode = v.op; in_group = v.grp; in_specifier = v.spec; in_funct3 = v.f3;
        in_funct7 = v.f7; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_imm20 = v.imm;
    endtask

    task automatic drive_addi(input int k);
        vec_t v;
        v = mk(7'h13, 2'b01, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'(k + 1), 21'(k * 3), 32'h0, 1'b0);
        drive(v);
    endtask

    function automatic logic [31:0] exp_addi(input int k);
        return {12'(k * 3), 5'd0, 3'd0, 5'(k + 1), 7'h13};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One word through an empty pipeline: out_valid must rise exactly one edge after acceptance.
    task automatic send_vec(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, v.instr);
        check({tag, "_err"}, 32'(out_err), 32'(v.err));
    endtask

    initial begin
        int tx;
        int rx;
        int c;

        vecs[0]  = mk(7'h33, 2'b01, 1'b0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 21'h000000, 32'h002081B3, 1'b0);
        vecs[1]  = mk(7'h33, 2'b01, 1'b0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 21'h1ABCDE, 32'h002081B3, 1'b0);
        vecs[2]  = mk(7'h13, 2'b01, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 21'h1FFFFF, 32'hFFF00293, 1'b0);
        vecs[3]  = mk(7'h13, 2'b01, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 21'h000800, 32'h00000013, 1'b1);
        vecs[4]  = mk(7'h23, 2'b10, 1'b0, 3'd2, 7'd0, 5'd2, 5'd5, 5'd0, 21'h000008, 32'h00512423, 1'b0);
        vecs[5]  = mk(7'h23, 2'b10, 1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h1FFFFF, 32'hFE000FA3, 1'b0);
        vecs[6]  = mk(7'h63, 2'b10, 1'b1, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 21'h1FFFFC, 32'hFE208EE3, 1'b0);
        vecs[7]  = mk(7'h63, 2'b10, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h000FFE, 32'h7E000FE3, 1'b0);
        vecs[8]  = mk(7'h63, 2'b10, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h001000, 32'h00000013, 1'b1);
        vecs[9]  = mk(7'h63, 2'b10, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h000003, 32'h00000013, 1'b1);
        vecs[10] = mk(7'h6F, 2'b11, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'h000800, 32'h001000EF, 1'b0);
        vecs[11] = mk(7'h6F, 2'b11, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h100000, 32'h8000006F, 1'b0);
        vecs[12] = mk(7'h6F, 2'b11, 1'b1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 21'h000001, 32'h00000013, 1'b1);
        vecs[13] = mk(7'h37, 2'b11, 1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd10, 21'h012345, 32'h12345537, 1'b0);
        vecs[14] = mk(7'h37, 2'b11, 1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd10, 21'h100000, 32'h00000013, 1'b1);
        vecs[15] = mk(7'h33, 2'b00, 1'b0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 21'h000000, 32'h00000013, 1'b1);
        vecs[16] = mk(7'h13, 2'b01, 1'b1, 3'd7, 7'd0, 5'd6, 5'd0, 5'd7, 21'h0007FF, 32'h7FF37393, 1'b0);

        do_reset();
        for (int i = 0; i < NumVecs; i++) begin
            send_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Ten back-to-back words, consumer stalled for cycles 3-7.
        do_reset();
        tx = 0; rx = 0; c = 0;
        while (rx < 10 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            if (tx < 10) begin
                drive_addi(tx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 5) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_held", 32'(tx - rx), 32'd2);
            end
            if (out_valid && !out_ready && rx < 10) check($sformatf("stall_hold%0d", rx), out_instr, exp_addi(rx));
            if (out_valid && out_ready) begin
                check($sformatf("bp_word%0d", rx), out_instr, exp_addi(rx));
                check($sformatf("bp_err%0d", rx), 32'(out_err), 32'd0);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            c++;
        end
        in_valid = 1'b0;
        check("bp_delivered", 32'(rx), 32'd10);
        @(negedge clk);
        check("bp_enc_count", 32'(enc_count), 32'd10);
        check("bp_err_count", 32'(err_count), 32'd0);

        // 260 illegal-group words drive err_count into saturation.
        do_reset();
        out_ready = 1'b1;
        drive(vecs[15]);
        tx = 0; rx = 0; c = 0;
        while (rx < 260 && c < 400) begin
            @(negedge clk);
            in_valid = (tx < 260);
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("sat_word%0d", rx), out_instr, 32'h00000013);
                check($sformatf("sat_err%0d", rx), 32'(out_err), 32'd1);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            c++;
        end
        in_valid = 1'b0;
        check("sat_delivered", 32'(rx), 32'd260);
        @(negedge clk);
        check("sat_enc_count", 32'(enc_count), 32'd260);
        check("sat_err_count", 32'(err_count), 32'd255);

        // Fill both stages under backpressure, then reset asynchronously.
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_enc_count", 32'(enc_count), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_vec("post_rst", vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
